fpu_result_uart_tx: RTL

//  - Downstream return path of the FPU test harness: buffers 16-bit FPU results and streams them
//    to the host over a UART TX line, the mirror of the programming UART RX.
//  - Each result is sent LSB byte first, as 8N1 frames, from a small FIFO that absorbs result bursts.

---
 rtl/fpu_result_uart_tx_if.sv | 8 +
 rtl/fpu_result_uart_tx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fpu_result_uart_tx_if.sv
// Result handshake from the FPU harness into the UART return path.
interface fpu_result_uart_tx_if;
    logic        result_valid;
    logic [15:0] result_data;

    modport master (output result_valid, output result_data);
    modport slave  (input  result_valid, input  result_data);
endinterface

// File: rtl/fpu_result_uart_tx.sv
// FPU result return path: small result FIFO feeding an 8N1 UART transmitter, LSB byte first.
// Optional sync header byte 8'hA5 per result when FPU_RESULT_TX_HEADER_EN is defined.
//
// state | meaning
// IDLE  | line high; pops the FIFO head when non-empty
// START | start bit (line 0) for one bit period
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (line 1); next byte of the result or back to IDLE
module fpu_result_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [15:0]          clks_per_bit,
    fpu_result_uart_tx_if.slave  res_if,
    output logic                 o_Tx_Serial,
    output logic                 tx_busy,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 fifo_full,
    output logic                 overflow,
    output logic                 overflow_seen
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

`ifdef FPU_RESULT_TX_HEADER_EN
    localparam logic [1:0] LAST_BYTE = 2'd2;
`else
    localparam logic [1:0] LAST_BYTE = 2'd1;
`endif
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    logic [15:0]        mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    state_t             state_q, state_d;
    logic [15:0]        hold_q, hold_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [15:0]        timer_q, timer_d;
    logic [15:0]        period_q, period_d;
    logic               tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_seen_q;

    logic        full, pop, push, drop, bit_end;
    logic [7:0]  cur_byte;
    logic [15:0] period_new;

    assign full       = (count_q == CNT_FULL);
    assign pop        = (state_q == IDLE) && (count_q != '0);
    // A pop in the same cycle frees a slot, so a push while full is still accepted.
    assign push       = res_if.result_valid && (!full || pop);
    assign drop       = res_if.result_valid && !push;
    assign bit_end    = (timer_q == period_q - 16'd1);
    assign period_new = (clks_per_bit < 16'd2) ? 16'd2 : clks_per_bit;

    always_comb begin
        cur_byte = hold_q[7:0];
`ifdef FPU_RESULT_TX_HEADER_EN
        case (byte_idx_q)
            2'd0:    cur_byte = 8'hA5;
            2'd1:    cur_byte = hold_q[7:0];
            default: cur_byte = hold_q[15:8];
        endcase
`else
        if (byte_idx_q != 2'd0) cur_byte = hold_q[15:8];
`endif
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        timer_d    = timer_q + 16'd1;
        period_d   = period_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pop) begin
                    hold_d     = mem_q[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    period_d   = period_new;
                    state_d    = START;
                end
            end
            START: if (bit_end) begin
                timer_d   = '0;
                bit_idx_d = 3'd0;
                state_d   = DATA;
            end
            DATA: if (bit_end) begin
                timer_d   = '0;
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) state_d = STOP;
            end
            STOP: if (bit_end) begin
                timer_d = '0;
                if (byte_idx_q == LAST_BYTE) begin
                    state_d = IDLE;
                end else begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    period_d   = period_new;
                    state_d    = START;
                end
            end
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Line is registered from the current state, so it lags the FSM by one cycle.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_q];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            timer_q    <= '0;
            period_q   <= 16'd2;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            timer_q    <= timer_d;
            period_q   <= period_d;
            count_q    <= count_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ovf_q      <= drop;
            ovf_seen_q <= ovf_seen_q | drop;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= res_if.result_data;
    end

    assign o_Tx_Serial   = tx_q;
    assign tx_busy       = busy_q;
    assign fifo_count    = count_q;
    assign fifo_full     = full;
    assign overflow      = ovf_q;
    assign overflow_seen = ovf_seen_q;
endmodule
